// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and its consumers.
// The timing generator drives it through the master modport.
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           pix_strb_i;
    logic [X_W-1:0] x_o;
    logic [Y_W-1:0] y_o;
    logic           de_o;
    logic           hsync_o;
    logic           vsync_o;
    logic           line_start_o;
    logic           frame_start_o;

    modport master (
        input  pix_strb_i,
        output x_o, y_o, de_o, hsync_o, vsync_o, line_start_o, frame_start_o
    );

    modport slave (
        output pix_strb_i,
        input  x_o, y_o, de_o, hsync_o, vsync_o, line_start_o, frame_start_o
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters advanced on the pixel strobe, with
// sync, display-enable and start pulses registered from next-state counters.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    vga_timing_gen_if.master   bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACT  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_BEG = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_ACT  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_BEG = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
            $error("vga_timing_gen: every porch, sync and active length must be at least 1");
        end
    endgenerate

    logic [X_W-1:0] r_x, w_x_nxt;
    logic [Y_W-1:0] r_y, w_y_nxt;
    logic           w_x_wrap, w_y_wrap;
    logic           r_de, r_hs, r_vs, r_ls, r_fs;

    // Wrap by compare so totals need not be powers of two.
    always_comb begin
        w_x_wrap = bus.pix_strb_i && (r_x == X_LAST);
        w_y_wrap = w_x_wrap && (r_y == Y_LAST);
        w_x_nxt  = r_x;
        w_y_nxt  = r_y;
        if (bus.pix_strb_i) begin
            w_x_nxt = w_x_wrap ? '0 : r_x + 1'b1;
            if (w_x_wrap) begin
                w_y_nxt = w_y_wrap ? '0 : r_y + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x  <= '0;
            r_y  <= '0;
            r_de <= 1'b1;
            r_hs <= ~HSYNC_POL;
            r_vs <= ~VSYNC_POL;
            r_ls <= 1'b0;
            r_fs <= 1'b0;
        end else begin
            r_x  <= w_x_nxt;
            r_y  <= w_y_nxt;
            r_de <= (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
            r_hs <= (w_x_nxt >= HS_BEG && w_x_nxt <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
            r_vs <= (w_y_nxt >= VS_BEG && w_y_nxt <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
            r_ls <= w_x_wrap;
            r_fs <= w_y_wrap;
        end
    end

    assign bus.x_o           = r_x;
    assign bus.y_o           = r_y;
    assign bus.de_o          = r_de;
    assign bus.hsync_o       = r_hs;
    assign bus.vsync_o       = r_vs;
    assign bus.line_start_o  = r_ls;
    assign bus.frame_start_o = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small rasters (both sync polarities) and the
// default 640x480 raster, checked against a pixel-index model of the raster.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Model state: linear pixel index within the frame plus pending pulses.
    int p_a = 0, p_b = 0, p_c = 0;
    bit ls_a = 0, fs_a = 0, ls_b = 0, fs_b = 0, ls_c = 0, fs_c = 0;

    vga_timing_gen_if #(.X_W(3),  .Y_W(3))  if_a ();
    vga_timing_gen_if #(.X_W(3),  .Y_W(3))  if_b ();
    vga_timing_gen_if #(.X_W(10), .Y_W(10)) if_c ();

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_a (.clk_i(clk), .rst_i(rst_a), .bus(if_a.master));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_b (.clk_i(clk), .rst_i(rst_b), .bus(if_b.master));

    vga_timing_gen u_c (.clk_i(clk), .rst_i(rst_c), .bus(if_c.master));

    function automatic logic [36:0] expv(int ha, int hfp, int hs, int hbp,
                                         int va, int vfp, int vs,
                                         bit hpol, bit vpol, int p, bit ls, bit fs);
        int  ht   = ha + hfp + hs + hbp;
        int  x    = p % ht;
        int  y    = p / ht;
        bit  hact = (x >= ha + hfp) && (x < ha + hfp + hs);
        bit  vact = (y >= va + vfp) && (y < va + vfp + vs);
        bit  de   = (x < ha) && (y < va);
        return {16'(x), 16'(y), de, hact ? hpol : ~hpol, vact ? vpol : ~vpol, ls, fs};
    endfunction

    function automatic logic [36:0] exp_a();
        return expv(4, 1, 2, 1, 3, 1, 1, 1'b0, 1'b0, p_a, ls_a, fs_a);
    endfunction
    function automatic logic [36:0] exp_b();
        return expv(4, 1, 2, 1, 3, 1, 1, 1'b1, 1'b1, p_b, ls_b, fs_b);
    endfunction
    function automatic logic [36:0] exp_c();
        return expv(640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0, p_c, ls_c, fs_c);
    endfunction

    function automatic logic [36:0] obs_a();
        return {16'(if_a.x_o), 16'(if_a.y_o), if_a.de_o, if_a.hsync_o, if_a.vsync_o,
                if_a.line_start_o, if_a.frame_start_o};
    endfunction
    function automatic logic [36:0] obs_b();
        return {16'(if_b.x_o), 16'(if_b.y_o), if_b.de_o, if_b.hsync_o, if_b.vsync_o,
                if_b.line_start_o, if_b.frame_start_o};
    endfunction
    function automatic logic [36:0] obs_c();
        return {16'(if_c.x_o), 16'(if_c.y_o), if_c.de_o, if_c.hsync_o, if_c.vsync_o,
                if_c.line_start_o, if_c.frame_start_o};
    endfunction

    task automatic model_step(input int ht, input int vt, input bit rst, input bit strb,
                              inout int p, inout bit ls, inout bit fs);
        if (rst) begin
            p = 0; ls = 0; fs = 0;
        end else if (strb) begin
            p  = (p + 1) % (ht * vt);
            ls = (p % ht == 0);
            fs = (p == 0);
        end else begin
            ls = 0; fs = 0;
        end
    endtask

    // One clock: advance all three models with the inputs present at the edge,
    // then land 1 time unit after the edge for sampling and new stimulus.
    task automatic cycle();
        @(posedge clk);
        model_step(8, 6, rst_a, if_a.pix_strb_i, p_a, ls_a, fs_a);
        model_step(8, 6, rst_b, if_b.pix_strb_i, p_b, ls_b, fs_b);
        model_step(800, 525, rst_c, if_c.pix_strb_i, p_c, ls_c, fs_c);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1; rst_c = 1;
        if_a.pix_strb_i = 1; if_b.pix_strb_i = 1; if_c.pix_strb_i = 1;
        repeat (3) cycle();
        n_chk++; if (obs_a() !== exp_a()) $display("FAIL reset_a: got %h want %h", obs_a(), exp_a()); else n_pass++;
        n_chk++; if (obs_b() !== exp_b()) $display("FAIL reset_b: got %h want %h", obs_b(), exp_b()); else n_pass++;
        n_chk++; if (obs_c() !== exp_c()) $display("FAIL reset_c: got %h want %h", obs_c(), exp_c()); else n_pass++;
        n_chk++;
        if (obs_b() !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_b_idle_low: got %h want %h", obs_b(), {32'd0, 5'b10000});
        else n_pass++;
        rst_a = 0; rst_b = 0; rst_c = 0;
        if_a.pix_strb_i = 0; if_b.pix_strb_i = 0; if_c.pix_strb_i = 0;
    endtask

    task automatic test_small_frame();
        int nls = 0, nfs = 0, fs_at = -1, hs_low = 0;
        for (int i = 0; i < 96; i++) begin
            if_a.pix_strb_i = (i % 2 == 0);
            cycle();
            n_chk++; if (obs_a() !== exp_a()) $display("FAIL frame_a cyc %0d: got %h want %h", i, obs_a(), exp_a()); else n_pass++;
            if (if_a.line_start_o) nls++;
            if (if_a.frame_start_o) begin
                nfs++;
                fs_at = i;
                n_chk++; if (if_a.line_start_o !== 1'b1) $display("FAIL frame_ls_coincide: got %b want 1", if_a.line_start_o); else n_pass++;
            end
            if (if_a.hsync_o === 1'b0) hs_low++;
        end
        if_a.pix_strb_i = 0;
        n_chk++; if (nls !== 6)    $display("FAIL line_start_count: got %0d want 6", nls); else n_pass++;
        n_chk++; if (nfs !== 1)    $display("FAIL frame_start_count: got %0d want 1", nfs); else n_pass++;
        n_chk++; if (fs_at !== 94) $display("FAIL frame_start_cycle: got %0d want 94", fs_at); else n_pass++;
        n_chk++; if (hs_low !== 24) $display("FAIL hsync_low_cycles: got %0d want 24", hs_low); else n_pass++;
    endtask

    task automatic test_reset_mid();
        rst_a = 1; cycle(); rst_a = 0;
        if_a.pix_strb_i = 1;
        repeat (19) begin
            cycle();
            n_chk++; if (obs_a() !== exp_a()) $display("FAIL mid_run: got %h want %h", obs_a(), exp_a()); else n_pass++;
        end
        n_chk++; if ({if_a.x_o, if_a.y_o} !== {3'd3, 3'd2}) $display("FAIL mid_position: got %0d,%0d want 3,2", if_a.x_o, if_a.y_o); else n_pass++;
        rst_a = 1;
        cycle();
        n_chk++;
        if (obs_a() !== {32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0})
            $display("FAIL mid_reset: got %h want %h", obs_a(), {32'd0, 5'b11100});
        else n_pass++;
        rst_a = 0; if_a.pix_strb_i = 0;
        cycle();
        n_chk++; if (obs_a() !== exp_a()) $display("FAIL after_reset_idle: got %h want %h", obs_a(), exp_a()); else n_pass++;
        if_a.pix_strb_i = 1;
        cycle();
        n_chk++; if (if_a.x_o !== 3'd1) $display("FAIL resume_x: got %0d want 1", if_a.x_o); else n_pass++;
        if_a.pix_strb_i = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if_a.pix_strb_i = 1'($urandom_range(0, 1));
            if_b.pix_strb_i = 1'($urandom_range(0, 1));
            rst_a = ($urandom_range(0, 49) == 0);
            rst_b = ($urandom_range(0, 49) == 0);
            cycle();
            n_chk++; if (obs_a() !== exp_a()) $display("FAIL random_a cyc %0d: got %h want %h", i, obs_a(), exp_a()); else n_pass++;
            n_chk++; if (obs_b() !== exp_b()) $display("FAIL random_b cyc %0d: got %h want %h", i, obs_b(), exp_b()); else n_pass++;
        end
        rst_a = 0; rst_b = 0;
        if_a.pix_strb_i = 0; if_b.pix_strb_i = 0;
    endtask

    task automatic test_pol_freeze();
        int hs_hi = 0, vs_hi = 0;
        rst_b = 1; cycle(); rst_b = 0;
        if_b.pix_strb_i = 1;
        for (int i = 0; i < 48; i++) begin
            cycle();
            n_chk++; if (obs_b() !== exp_b()) $display("FAIL pol_run cyc %0d: got %h want %h", i, obs_b(), exp_b()); else n_pass++;
            if (if_b.hsync_o === 1'b1) hs_hi++;
            if (if_b.vsync_o === 1'b1) vs_hi++;
        end
        n_chk++; if (hs_hi !== 12) $display("FAIL pol_hsync_high: got %0d want 12", hs_hi); else n_pass++;
        n_chk++; if (vs_hi !== 8)  $display("FAIL pol_vsync_high: got %0d want 8", vs_hi); else n_pass++;
        repeat (37) cycle();
        if_b.pix_strb_i = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            n_chk++; if (obs_b() !== exp_b()) $display("FAIL freeze cyc %0d: got %h want %h", i, obs_b(), exp_b()); else n_pass++;
        end
        n_chk++; if (if_b.line_start_o !== 1'b0) $display("FAIL freeze_pulse: got %b want 0", if_b.line_start_o); else n_pass++;
    endtask

    task automatic test_default_hsync();
        int fall1 = -1, fall2 = -1, low_cnt = 0, vs_low = 0;
        logic prev_hs = 1'b1;
        if_c.pix_strb_i = 1;
        for (int i = 0; i < 2600; i++) begin
            cycle();
            n_chk++; if (obs_c() !== exp_c()) $display("FAIL default cyc %0d: got %h want %h", i, obs_c(), exp_c()); else n_pass++;
            if (prev_hs === 1'b1 && if_c.hsync_o === 1'b0) begin
                if (fall1 < 0) fall1 = i;
                else if (fall2 < 0) fall2 = i;
            end
            if (fall1 >= 0 && fall2 < 0 && if_c.hsync_o === 1'b0) low_cnt++;
            if (if_c.vsync_o !== 1'b1) vs_low++;
            prev_hs = if_c.hsync_o;
        end
        if_c.pix_strb_i = 0;
        n_chk++; if (fall1 !== 655)         $display("FAIL hsync_first_fall: got %0d want 655", fall1); else n_pass++;
        n_chk++; if (fall2 - fall1 !== 800) $display("FAIL hsync_period: got %0d want 800", fall2 - fall1); else n_pass++;
        n_chk++; if (low_cnt !== 96)        $display("FAIL hsync_width: got %0d want 96", low_cnt); else n_pass++;
        n_chk++; if (vs_low !== 0)          $display("FAIL vsync_idle: got %0d low cycles want 0", vs_low); else n_pass++;
    endtask

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1;
        if_a.pix_strb_i = 0; if_b.pix_strb_i = 0; if_c.pix_strb_i = 0;
        #1;
        test_reset();
        test_small_frame();
        test_reset_mid();
        test_random();
        test_pol_freeze();
        test_default_hsync();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
